// File: rtl/wb_stage.sv
// RV32 writeback stage: retires ALU/link results in one cycle and load results after the
// data-memory response. Optional retire counter is enabled with `define WB_RETIRE_COUNT_EN.
module wb_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wb_en,
    input  logic [1:0]        in_wb_sel,
    input  logic [XLEN-1:0]   in_alu_res,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic [2:0]        in_funct3,

    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,

    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wd,
    output logic              rf_we,

    output logic              load_pending,
    output logic [REG_AW-1:0] load_rd,
    output logic              stray_rsp
`ifdef WB_RETIRE_COUNT_EN
    ,
    input  logic              retire_clr,
    output logic [63:0]       retire_cnt
`endif
);

    localparam logic [1:0] SelAlu  = 2'b00;
    localparam logic [1:0] SelLoad = 2'b01;
    localparam logic [1:0] SelPc4  = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StWaitLoad
    } state_e;

    state_e state_q, state_d;

    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic              ld_wb_en_q, ld_wb_en_d;
    logic [2:0]        ld_funct3_q, ld_funct3_d;
    logic [1:0]        ld_off_q, ld_off_d;

    logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
    logic              rf_we_q, rf_we_d;
    logic              stray_q, stray_d;

    // High in the cycle a write slot is scheduled, even when the write is suppressed.
    logic              slot_fire;
    logic              accept;

    // Byte/halfword select and extension; off[0] is ignored for halfwords.
    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]      f3,
                                                 input logic [1:0]      off,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'b0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'b0, h};
            default: fmt_load = w;
        endcase
    endfunction

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_wb_en_d  = ld_wb_en_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        rf_rd_d     = rf_rd_q;
        rf_wd_d     = rf_wd_q;
        rf_we_d     = 1'b0;
        stray_d     = stray_q;
        slot_fire   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A response with no load outstanding is dropped and flagged.
                if (dmem_rvalid) begin
                    stray_d = 1'b1;
                end
                if (accept) begin
                    if (in_wb_sel == SelLoad) begin
                        ld_rd_d     = in_rd;
                        ld_wb_en_d  = in_wb_en;
                        ld_funct3_d = in_funct3;
                        ld_off_d    = in_alu_res[1:0];
                        state_d     = StWaitLoad;
                    end else begin
                        slot_fire = 1'b1;
                        rf_rd_d   = in_rd;
                        rf_we_d   = in_wb_en && (in_rd != '0);
                        rf_wd_d   = (in_wb_sel == SelPc4) ? in_pc4 : in_alu_res;
                    end
                end
            end
            StWaitLoad: begin
                if (dmem_rvalid) begin
                    slot_fire = 1'b1;
                    rf_rd_d   = ld_rd_q;
                    rf_we_d   = ld_wb_en_q && (ld_rd_q != '0);
                    rf_wd_d   = fmt_load(ld_funct3_q, ld_off_q, dmem_rdata);
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ld_rd_q     <= '0;
            ld_wb_en_q  <= 1'b0;
            ld_funct3_q <= '0;
            ld_off_q    <= '0;
            rf_rd_q     <= '0;
            rf_wd_q     <= '0;
            rf_we_q     <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_wb_en_q  <= ld_wb_en_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            rf_rd_q     <= rf_rd_d;
            rf_wd_q     <= rf_wd_d;
            rf_we_q     <= rf_we_d;
            stray_q     <= stray_d;
        end
    end

    assign rf_rd        = rf_rd_q;
    assign rf_wd        = rf_wd_q;
    assign rf_we        = rf_we_q;
    assign stray_rsp    = stray_q;
    assign load_pending = (state_q == StWaitLoad);
    assign load_rd      = load_pending ? ld_rd_q : '0;

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    // Counter advances on the same edge that registers the write slot; clear wins.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire_clr) begin
            retire_cnt_d = '0;
        end else if (slot_fire) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    logic unused_slot_fire;
    assign unused_slot_fire = slot_fire;
`endif

    logic unused_sel;
    assign unused_sel = (SelAlu == 2'b00);

endmodule
